// File: rtl/timer_pkg.sv
// Shared definitions for the hours:minutes:seconds timer: default moduli,
// field widths and the packed time record used by the display/alarm stages.
package timer_pkg;

  localparam int DEF_SEC_MOD = 60;
  localparam int DEF_MIN_MOD = 60;
  localparam int DEF_HR_MOD  = 24;

  // Width needed to hold 0..m-1; never below one bit.
  function automatic int field_w(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int SEC_W = field_w(DEF_SEC_MOD);
  localparam int MIN_W = field_w(DEF_MIN_MOD);
  localparam int HR_W  = field_w(DEF_HR_MOD);

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } hms_t;

endpackage

// File: rtl/mod_counter.sv
// One time field: modulo-MOD up/down counter with clear, load and a
// combinational carry that enables the next field in the cascade.
module mod_counter
  import timer_pkg::*;
#(
  parameter  int MOD = 60,
  localparam int W   = field_w(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dn,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0] value_q, value_d;
  logic         at_max, at_min;

  assign at_max = (value_q == MAXV);
  assign at_min = (value_q == '0);

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (ld) begin
      value_d = ld_val;
    end else if (en) begin
      if (dn) value_d = at_min ? MAXV : value_q - W'(1);
      else    value_d = at_max ? '0   : value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  // Carry means wrap when counting up, borrow when counting down.
  assign carry = en & (dn ? at_min : at_max);
  assign value = value_q;

endmodule

// File: rtl/hms_timer_core.sv
// Hours:minutes:seconds timer: prescaled seconds tick, cascaded field counters,
// run/pause control, validated load and down-count expiry detection.
module hms_timer_core
  import timer_pkg::*;
#(
  parameter  int TICK_DIV = 50_000_000,
  parameter  int SEC_MOD  = DEF_SEC_MOD,
  parameter  int MIN_MOD  = DEF_MIN_MOD,
  parameter  int HR_MOD   = DEF_HR_MOD,
  localparam int SW       = field_w(SEC_MOD),
  localparam int MW       = field_w(MIN_MOD),
  localparam int HW       = field_w(HR_MOD),
  localparam int PW       = field_w(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          count_down,
  input  logic          load,
  input  logic [HW-1:0] ld_hr,
  input  logic [MW-1:0] ld_min,
  input  logic [SW-1:0] ld_sec,
  output logic [HW-1:0] hr,
  output logic [MW-1:0] min,
  output logic [SW-1:0] sec,
  output logic          sec_pulse,
  output logic          min_pulse,
  output logic          hr_pulse,
  output logic          rollover,
  output logic          expired,
  output logic          load_err,
  output logic          running
);

  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          sec_pulse_q, min_pulse_q, hr_pulse_q;
  logic          rollover_q, expired_q, load_err_q;

  logic load_ok, load_acc, load_rej;
  logic advance, at_wrap, tick, all_zero, exp_hit, en_sec;
  logic sec_carry, min_carry, hr_carry;

  assign load_ok  = (int'(ld_sec) < SEC_MOD) && (int'(ld_min) < MIN_MOD) &&
                    (int'(ld_hr) < HR_MOD);
  assign load_acc = load & ~clear & load_ok;
  assign load_rej = load & ~clear & ~load_ok;

  // A stop in the same cycle freezes the prescaler where it is, so a later
  // start resumes the partial second rather than restarting it.
  assign advance  = running_q & ~stop;
  assign at_wrap  = (presc_q == PW'(TICK_DIV - 1));
  assign tick     = advance & at_wrap & ~clear & ~load_acc;

  assign all_zero = (sec == '0) && (min == '0) && (hr == '0);
  assign exp_hit  = tick & count_down & all_zero;
  assign en_sec   = tick & ~exp_hit;

  always_comb begin
    presc_d = presc_q;
    if (clear || load_acc)  presc_d = '0;
    else if (advance)       presc_d = at_wrap ? '0 : presc_q + PW'(1);
  end

  assign running_d = ~stop & ~exp_hit & (running_q | start);

  mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk(clk), .rst_n(rst_n), .en(en_sec), .dn(count_down), .ld(load_acc),
    .ld_val(ld_sec), .clr(clear), .value(sec), .carry(sec_carry)
  );

  mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .rst_n(rst_n), .en(sec_carry), .dn(count_down), .ld(load_acc),
    .ld_val(ld_min), .clr(clear), .value(min), .carry(min_carry)
  );

  mod_counter #(.MOD(HR_MOD)) u_hr (
    .clk(clk), .rst_n(rst_n), .en(min_carry), .dn(count_down), .ld(load_acc),
    .ld_val(ld_hr), .clr(clear), .value(hr), .carry(hr_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      running_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      hr_pulse_q  <= 1'b0;
      rollover_q  <= 1'b0;
      expired_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      running_q   <= running_d;
      sec_pulse_q <= en_sec;
      min_pulse_q <= sec_carry;
      hr_pulse_q  <= min_carry;
      rollover_q  <= hr_carry & ~count_down;
      expired_q   <= exp_hit;
      load_err_q  <= load_rej;
    end
  end

  assign sec_pulse = sec_pulse_q;
  assign min_pulse = min_pulse_q;
  assign hr_pulse  = hr_pulse_q;
  assign rollover  = rollover_q;
  assign expired   = expired_q;
  assign load_err  = load_err_q;
  assign running   = running_q;

endmodule
